// File: rtl/spi_slave_if.sv
// SPI pins plus the byte-wide transmit/receive handshakes of the SPI slave.
`timescale 1ns/1ps
interface spi_slave_if;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_overrun;
    logic       tx_underrun;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid, rx_ready,
        output miso, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid, rx_ready,
        input  miso, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, 8-bit frames, oversampled by clk (sclk <= clk/8).
// One-byte transmit buffer; DUMMY is shifted out whenever that buffer is empty.
`timescale 1ns/1ps
module spi_slave #(
    parameter logic [7:0] DUMMY = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    spi_slave_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state;
    logic [2:0] sclk_sync;
    logic [2:0] cs_sync;
    logic [1:0] mosi_sync;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] tx_buf;
    logic       buf_full;
    logic       rose_seen;
    logic       miso_reg;
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       rx_overrun_reg;
    logic       tx_underrun_reg;

    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_fall;
    logic       cs_rise;
    logic [7:0] rx_byte;
    logic [7:0] load_val;
    logic       do_load;
    logic       accept;

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign rx_byte   = {rx_shift[6:0], mosi_sync[1]};
    assign load_val  = buf_full ? tx_buf : DUMMY;
    assign accept    = bus.tx_valid & ~buf_full;

    // Byte-boundary reload needs a rise in this frame so the first fall after cs_n drops never reloads.
    assign do_load = ((state == IDLE) && cs_fall) ||
                     ((state == ACTIVE) && !cs_rise && sclk_fall && (bit_cnt == 3'd0) && rose_seen);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            // cs_n synchronizer clears low so a master already holding cs_n low cannot restart a frame.
            sclk_sync       <= 3'b000;
            cs_sync         <= 3'b000;
            mosi_sync       <= 2'b00;
            bit_cnt         <= 3'd0;
            rx_shift        <= 8'h00;
            tx_shift        <= 8'h00;
            tx_buf          <= 8'h00;
            buf_full        <= 1'b0;
            rose_seen       <= 1'b0;
            miso_reg        <= 1'b0;
            rx_data_reg     <= 8'h00;
            rx_valid_reg    <= 1'b0;
            rx_overrun_reg  <= 1'b0;
            tx_underrun_reg <= 1'b0;
        end else begin
            sclk_sync       <= {sclk_sync[1:0], bus.sclk};
            cs_sync         <= {cs_sync[1:0], bus.cs_n};
            mosi_sync       <= {mosi_sync[0], bus.mosi};
            rx_overrun_reg  <= 1'b0;
            tx_underrun_reg <= 1'b0;

            if (rx_valid_reg && bus.rx_ready)
                rx_valid_reg <= 1'b0;

            if (accept) begin
                tx_buf   <= bus.tx_data;
                buf_full <= 1'b1;
            end

            if (do_load) begin
                tx_shift <= load_val;
                miso_reg <= load_val[7];
                if (buf_full)
                    buf_full <= 1'b0;
                else
                    tx_underrun_reg <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= ACTIVE;
                        bit_cnt   <= 3'd0;
                        rx_shift  <= 8'h00;
                        rose_seen <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        bit_cnt   <= 3'd0;
                        rx_shift  <= 8'h00;
                        rose_seen <= 1'b0;
                        miso_reg  <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift  <= rx_byte;
                            bit_cnt   <= bit_cnt + 3'd1;
                            rose_seen <= 1'b1;
                            if (bit_cnt == 3'd7) begin
                                if (!rx_valid_reg || bus.rx_ready) begin
                                    rx_data_reg  <= rx_byte;
                                    rx_valid_reg <= 1'b1;
                                end else begin
                                    rx_overrun_reg <= 1'b1;
                                end
                            end
                        end
                        if (sclk_fall && (bit_cnt != 3'd0)) begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            miso_reg <= tx_shift[6];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.miso        = miso_reg;
    assign bus.tx_ready    = ~buf_full;
    assign bus.rx_data     = rx_data_reg;
    assign bus.rx_valid    = rx_valid_reg;
    assign bus.rx_overrun  = rx_overrun_reg;
    assign bus.tx_underrun = tx_underrun_reg;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed frame table, hand-written corner sequences, randomized frames.
`timescale 1ns/1ps
module tb_spi_slave;
    localparam logic [7:0] DUMMY = 8'hFF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    spi_slave_if bus();

    spi_slave #(.DUMMY(DUMMY)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        bit         has_buf;
        logic [7:0] buf_val;
        logic [7:0] mosi_val;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_und;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         ovr_cnt = 0;
    int         und_cnt = 0;
    logic [7:0] rxq[$];
    logic [7:0] m_out[4];
    logic [7:0] m_in[4];
    logic       prev_hold;
    logic [7:0] prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_miso"}, 32'(bus.miso), 32'd0);
        chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
        chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
        chk({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
        chk({tag, "_rx_overrun"}, 32'(bus.rx_overrun), 32'd0);
        chk({tag, "_tx_underrun"}, 32'(bus.tx_underrun), 32'd0);
    endtask

    task automatic push_tx(input logic [7:0] v);
        int k = 0;
        while (!bus.tx_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("push_ready", 32'(bus.tx_ready), 32'd1);
        bus.tx_data  = v;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        chk("tx_ready_drop", 32'(bus.tx_ready), 32'd0);
    endtask

    // Mode-0 master; the last falling sclk edge coincides with cs_n rising.
    task automatic frame(input int n, input bit refill, input logic [7:0] rv);
        bus.cs_n = 1'b0;
        bus.mosi = m_out[0][7];
        wait_clk(5);
        for (int b = 0; b < n; b++) begin
            for (int i = 7; i >= 0; i--) begin
                bus.sclk = 1'b1;
                m_in[b][i] = bus.miso;
                if (refill && b == 0 && i == 7) begin
                    wait_clk(1);
                    chk("refill_ready", 32'(bus.tx_ready), 32'd1);
                    bus.tx_data  = rv;
                    bus.tx_valid = 1'b1;
                    wait_clk(1);
                    bus.tx_valid = 1'b0;
                    wait_clk(3);
                end else begin
                    wait_clk(5);
                end
                bus.sclk = 1'b0;
                if (b == n - 1 && i == 0) bus.cs_n = 1'b1;
                else if (i > 0)           bus.mosi = m_out[b][i - 1];
                else                      bus.mosi = m_out[b + 1][7];
                wait_clk(5);
            end
        end
        wait_clk(4);
    endtask

    task automatic partial(input int nbits, input logic [7:0] v, input bit do_reset);
        bus.cs_n = 1'b0;
        bus.mosi = v[7];
        wait_clk(5);
        for (int i = 0; i < nbits; i++) begin
            bus.sclk = 1'b1;
            wait_clk(5);
            bus.sclk = 1'b0;
            bus.mosi = v[6 - i];
            wait_clk(5);
        end
        if (do_reset) begin
            push_tx(8'h77);
            reset = 1'b1;
            wait_clk(1);
            check_reset_state("mid_reset");
            reset = 1'b0;
        end
        bus.cs_n = 1'b1;
        wait_clk(6);
    endtask

    initial begin
        prev_hold = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) chk("rx_hold", 32'(bus.rx_data), 32'(prev_data));
                if (bus.rx_overrun) ovr_cnt++;
                if (bus.tx_underrun) und_cnt++;
                if (bus.rx_valid && bus.rx_ready) rxq.push_back(bus.rx_data);
                prev_hold = bus.rx_valid && !bus.rx_ready;
                prev_data = bus.rx_data;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[4];
        int         u0, o0, n, exp_und, exp_ovr;
        bit         has_buf, refill, rdy;
        logic [7:0] bv, rv;
        logic [7:0] exp_miso[2];
        logic [7:0] exp_rx[$];

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
        vecs[1] = '{1'b0, 8'h00, 8'h5A, DUMMY, 8'h5A, 1};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
        vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h80, 8'h01, 0};

        bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
        bus.tx_data = 8'h00; bus.tx_valid = 1'b0; bus.rx_ready = 1'b1;
        reset = 1'b1;
        wait_clk(3);
        check_reset_state("por");
        reset = 1'b0;
        wait_clk(4);

        for (int v = 0; v < 4; v++) begin
            rxq.delete();
            u0 = und_cnt; o0 = ovr_cnt;
            if (vecs[v].has_buf) push_tx(vecs[v].buf_val);
            m_out[0] = vecs[v].mosi_val;
            frame(1, 1'b0, 8'h00);
            chk("vec_miso", 32'(m_in[0]), 32'(vecs[v].exp_miso));
            chk("vec_rx_count", 32'(rxq.size()), 32'd1);
            if (rxq.size() > 0) chk("vec_rx_byte", 32'(rxq[0]), 32'(vecs[v].exp_rx));
            chk("vec_underrun", 32'(und_cnt - u0), 32'(vecs[v].exp_und));
            chk("vec_overrun", 32'(ovr_cnt - o0), 32'd0);
            chk("vec_tx_ready", 32'(bus.tx_ready), 32'd1);
        end

        // sclk activity with cs_n high must do nothing
        rxq.delete(); u0 = und_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.mosi = 1'b1; bus.sclk = ~bus.sclk; wait_clk(5);
        end
        bus.sclk = 1'b0; wait_clk(5);
        chk("idle_rx_count", 32'(rxq.size()), 32'd0);
        chk("idle_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("idle_underrun", 32'(und_cnt - u0), 32'd0);
        chk("idle_miso", 32'(bus.miso), 32'd0);

        // overrun: second byte dropped while the first is unread
        rxq.delete(); u0 = und_cnt; o0 = ovr_cnt;
        bus.rx_ready = 1'b0;
        m_out[0] = 8'h01; frame(1, 1'b0, 8'h00);
        m_out[0] = 8'h02; frame(1, 1'b0, 8'h00);
        chk("ovr_rx_valid", 32'(bus.rx_valid), 32'd1);
        chk("ovr_rx_data", 32'(bus.rx_data), 32'h01);
        chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        chk("ovr_underruns", 32'(und_cnt - u0), 32'd2);
        bus.rx_ready = 1'b1;
        wait_clk(2);
        chk("ovr_drain_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) chk("ovr_drain_byte", 32'(rxq[0]), 32'h01);
        chk("ovr_rx_valid_clear", 32'(bus.rx_valid), 32'd0);

        // two bytes under one cs_n, buffer refilled mid-frame
        rxq.delete(); u0 = und_cnt;
        push_tx(8'h11);
        m_out[0] = 8'h96; m_out[1] = 8'h69;
        frame(2, 1'b1, 8'h22);
        chk("b2b_miso0", 32'(m_in[0]), 32'h11);
        chk("b2b_miso1", 32'(m_in[1]), 32'h22);
        chk("b2b_underrun", 32'(und_cnt - u0), 32'd0);
        chk("b2b_rx_count", 32'(rxq.size()), 32'd2);
        if (rxq.size() == 2) begin
            chk("b2b_rx0", 32'(rxq[0]), 32'h96);
            chk("b2b_rx1", 32'(rxq[1]), 32'h69);
        end

        // cs_n abort after 5 bits, then a full frame
        rxq.delete();
        partial(5, 8'hAB, 1'b0);
        chk("abort_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("abort_rx_count", 32'(rxq.size()), 32'd0);
        chk("abort_rx_data_kept", 32'(bus.rx_data), 32'h69);
        m_out[0] = 8'hC3; frame(1, 1'b0, 8'h00);
        chk("abort_next_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) chk("abort_next_byte", 32'(rxq[0]), 32'hC3);

        // reset after 4 bits; buffered 8'h77 must be discarded by reset
        rxq.delete();
        partial(4, 8'h5C, 1'b1);
        u0 = und_cnt;
        m_out[0] = 8'hE7; frame(1, 1'b0, 8'h00);
        chk("rst_next_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) chk("rst_next_byte", 32'(rxq[0]), 32'hE7);
        chk("rst_next_miso", 32'(m_in[0]), 32'(DUMMY));
        chk("rst_next_underrun", 32'(und_cnt - u0), 32'd1);

        // randomized frames against a byte-level model
        for (int it = 0; it < 20; it++) begin
            has_buf = 1'($urandom_range(0, 1));
            bv      = 8'($urandom);
            n       = int'($urandom_range(1, 2));
            refill  = (n == 2) && ($urandom_range(0, 1) == 1);
            rv      = 8'($urandom);
            rdy     = 1'($urandom_range(0, 1));
            m_out[0] = 8'($urandom);
            m_out[1] = 8'($urandom);

            exp_miso[0] = has_buf ? bv : DUMMY;
            exp_miso[1] = refill ? rv : DUMMY;
            exp_und = (has_buf ? 0 : 1) + ((n == 2 && !refill) ? 1 : 0);
            exp_rx.delete();
            exp_rx.push_back(m_out[0]);
            if (rdy && n == 2) exp_rx.push_back(m_out[1]);
            exp_ovr = rdy ? 0 : n - 1;

            rxq.delete(); u0 = und_cnt; o0 = ovr_cnt;
            bus.rx_ready = rdy;
            if (has_buf) push_tx(bv);
            frame(n, refill, rv);
            bus.rx_ready = 1'b1;
            wait_clk(3);

            for (int b = 0; b < n; b++) chk("rnd_miso", 32'(m_in[b]), 32'(exp_miso[b]));
            chk("rnd_underrun", 32'(und_cnt - u0), 32'(exp_und));
            chk("rnd_overrun", 32'(ovr_cnt - o0), 32'(exp_ovr));
            chk("rnd_rx_count", 32'(rxq.size()), 32'(exp_rx.size()));
            if (rxq.size() == exp_rx.size())
                foreach (exp_rx[k]) chk("rnd_rx_byte", 32'(rxq[k]), 32'(exp_rx[k]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
